// File: rtl/ddr_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ddr_bus_arbiter: two-master burst arbiter for the shared DDR bus            |
// | (M0 = GPU memory traffic, M1 = display scan-out). Rev 1.0                   |
// +----------------------------------------------------------------------------+
module ddr_bus_arbiter #(
  parameter int ADR_W      = 20,
  parameter int DAT_W      = 32,
  parameter int CNT_W      = 3,
  parameter int MAX_STREAK = 4
) (
  input  logic             gpuClk,
  input  logic             i_Rst,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [CNT_W-1:0] m0_cnt_i,
  input  logic [3:0]       m0_sel_i,
  input  logic             m0_wrt_i,
  input  logic             m0_req_i,
  output logic             m0_ack_o,
  output logic [DAT_W-1:0] m0_dat_o,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [CNT_W-1:0] m1_cnt_i,
  input  logic [3:0]       m1_sel_i,
  input  logic             m1_wrt_i,
  input  logic             m1_req_i,
  output logic             m1_ack_o,
  output logic [DAT_W-1:0] m1_dat_o,
  input  logic             i_dispUrgent,
  output logic [ADR_W-1:0] adr_o,
  output logic [DAT_W-1:0] dat_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [3:0]       sel_o,
  output logic             wrt_o,
  output logic             req_o,
  input  logic [DAT_W-1:0] dat_i,
  input  logic             ack_i,
  output logic             o_owner,
  output logic             o_busy
);

  localparam int c_STRK_W = $clog2(MAX_STREAK + 1);
  localparam logic [c_STRK_W-1:0] c_MAX_STREAK = c_STRK_W'(MAX_STREAK);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic                  r_owner;
  logic                  r_last;
  logic [CNT_W-1:0]      r_cntReg;
  logic [CNT_W-1:0]      r_beat;
  logic [c_STRK_W-1:0]   r_streak;
  logic                  w_pick;
  logic                  w_grant;
  logic                  w_final;
  logic                  w_busy;
  logic                  w_ownerReq;

  assign w_busy     = (r_state == BUSY);
  assign w_ownerReq = r_owner ? m1_req_i : m0_req_i;

  always_comb begin
    w_nextState = r_state;
    w_grant     = 1'b0;
    w_final     = 1'b0;
    // Urgent display first, then a lone requester, then streak cap / round-robin.
    if (m1_req_i && i_dispUrgent)
      w_pick = 1'b1;
    else if (m0_req_i != m1_req_i)
      w_pick = m1_req_i;
    else if (r_streak == c_MAX_STREAK)
      w_pick = 1'b1;
    else
      w_pick = ~r_last;
    case (r_state)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          w_grant     = 1'b1;
          w_nextState = BUSY;
        end
      end
      BUSY: begin
        if (ack_i && (r_beat == r_cntReg)) begin
          w_final     = 1'b1;
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge gpuClk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state  <= IDLE;
      r_owner  <= 1'b0;
      r_last   <= 1'b1;
      r_cntReg <= '0;
      r_beat   <= '0;
      r_streak <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_grant) begin
        r_owner  <= w_pick;
        r_cntReg <= w_pick ? m1_cnt_i : m0_cnt_i;
        r_beat   <= '0;
        if (w_pick)
          r_streak <= '0;
        else if (r_streak != c_MAX_STREAK)
          r_streak <= r_streak + 1'b1;
      end
      if (w_busy && ack_i)
        r_beat <= r_beat + 1'b1;
      if (w_final)
        r_last <= r_owner;
    end
  end

  // Slave side is driven only while a burst is in flight; idle bus is all-zero.
  always_comb begin
    adr_o    = '0;
    dat_o    = '0;
    cnt_o    = '0;
    sel_o    = '0;
    wrt_o    = 1'b0;
    req_o    = 1'b0;
    m0_ack_o = 1'b0;
    m1_ack_o = 1'b0;
    m0_dat_o = '0;
    m1_dat_o = '0;
    if (w_busy) begin
      adr_o    = r_owner ? m1_adr_i : m0_adr_i;
      dat_o    = r_owner ? m1_dat_i : m0_dat_i;
      cnt_o    = r_owner ? m1_cnt_i : m0_cnt_i;
      sel_o    = r_owner ? m1_sel_i : m0_sel_i;
      wrt_o    = r_owner ? m1_wrt_i : m0_wrt_i;
      req_o    = w_ownerReq;
      m0_ack_o = ack_i & ~r_owner;
      m1_ack_o = ack_i & r_owner;
      m0_dat_o = dat_i;
      m1_dat_o = dat_i;
    end
  end

  assign o_owner = r_owner;
  assign o_busy  = w_busy;

  // The owner must keep requesting until its last beat is acknowledged.
  a_ownerHoldsReq: assert property (@(posedge gpuClk) disable iff (i_Rst)
    w_busy |-> w_ownerReq);

endmodule
`default_nettype wire

// File: tb/tb_ddr_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ddr_bus_arbiter: table vectors, directed bursts and randomized traffic   |
// | against a burst-level reference model. Rev 1.0                              |
// +----------------------------------------------------------------------------+
module tb_ddr_bus_arbiter;

  logic             gpuClk = 1'b0;
  logic             rst    = 1'b1;
  logic [1:0]       rq     = '0;
  logic [1:0]       wr     = '0;
  logic [1:0][19:0] ad     = '0;
  logic [1:0][31:0] dw     = '0;
  logic [1:0][2:0]  cn     = '0;
  logic [1:0][3:0]  sl     = '0;
  logic             urg    = 1'b0;
  logic [31:0]      dI     = '0;
  logic             ackI   = 1'b0;

  logic        m0Ack, m1Ack, wrtO, reqO, owner, busy;
  logic [31:0] m0DatO, m1DatO, datO;
  logic [19:0] adrO;
  logic [2:0]  cntO;
  logic [3:0]  selO;

  ddr_bus_arbiter dut (
    .gpuClk(gpuClk), .i_Rst(rst),
    .m0_adr_i(ad[0]), .m0_dat_i(dw[0]), .m0_cnt_i(cn[0]), .m0_sel_i(sl[0]),
    .m0_wrt_i(wr[0]), .m0_req_i(rq[0]), .m0_ack_o(m0Ack), .m0_dat_o(m0DatO),
    .m1_adr_i(ad[1]), .m1_dat_i(dw[1]), .m1_cnt_i(cn[1]), .m1_sel_i(sl[1]),
    .m1_wrt_i(wr[1]), .m1_req_i(rq[1]), .m1_ack_o(m1Ack), .m1_dat_o(m1DatO),
    .i_dispUrgent(urg),
    .adr_o(adrO), .dat_o(datO), .cnt_o(cntO), .sel_o(selO), .wrt_o(wrtO), .req_o(reqO),
    .dat_i(dI), .ack_i(ackI), .o_owner(owner), .o_busy(busy)
  );

  always #5 gpuClk = ~gpuClk;

  int nChecks = 0;
  int nFail   = 0;

  // Burst-level reference model: who owns the bus and how many beats remain.
  int         mBusy, mOwner, mLeft, mLast, mStreak;
  logic [1:0] mDone;
  int         prevBusy;
  bit         autoDrop;
  int         ack0Cnt, ack1Cnt;
  int         grantQ[$];
  logic [31:0] wdatQ[$];

  typedef struct packed {
    logic [1:0] rq;
    logic       ack;
    logic       eBusy;
    logic       eOwn;
    logic       eA0;
    logic       eA1;
    logic       eReq;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mBusy = 0; mOwner = 0; mLeft = 0; mLast = 1; mStreak = 0;
    mDone = '0; prevBusy = 0;
  endtask

  task automatic modelEdge();
    int p;
    if (mBusy == 0) begin
      if (rq != 2'b00) begin
        if (rq[1] && urg)                     p = 1;
        else if (rq == 2'b01)                 p = 0;
        else if (rq == 2'b10)                 p = 1;
        else if (mStreak >= 4)                p = 1;
        else                                  p = 1 - mLast;
        mOwner  = p;
        mLeft   = int'(cn[p]) + 1;
        mStreak = (p == 1) ? 0 : ((mStreak + 1 > 4) ? 4 : mStreak + 1);
        mBusy   = 1;
      end
    end else if (ackI) begin
      mLeft--;
      if (mLeft == 0) begin
        mBusy = 0;
        mLast = mOwner;
        mDone[mOwner] = 1'b1;
      end
    end
  endtask

  task automatic checkModel();
    check("busy", busy, mBusy[0]);
    if (mBusy != 0) begin
      check("owner", owner, mOwner[0]);
      check("req_o", reqO, rq[mOwner]);
      check("adr_o", adrO, ad[mOwner]);
      check("dat_o", datO, dw[mOwner]);
      check("cnt_o", cntO, cn[mOwner]);
      check("sel_o", selO, sl[mOwner]);
      check("wrt_o", wrtO, wr[mOwner]);
      check("m0_ack_o", m0Ack, ackI && mOwner == 0);
      check("m1_ack_o", m1Ack, ackI && mOwner == 1);
      check("m0_dat_o", m0DatO, dI);
      check("m1_dat_o", m1DatO, dI);
    end else begin
      check("idle_slave", {reqO, wrtO, selO, adrO, cntO}, '0);
      check("idle_acks", {m0Ack, m1Ack}, '0);
    end
  endtask

  task automatic checkAllZero(input string nm);
    check(nm, {busy, owner, reqO, wrtO, m0Ack, m1Ack, selO, cntO, adrO}, '0);
    check(nm, {datO, m0DatO}, '0);
    check(nm, m1DatO, '0);
  endtask

  // One clock: compare, advance model on the edge, return at the next falling edge.
  task automatic cyc();
    #1;
    checkModel();
    ack0Cnt += int'(m0Ack);
    ack1Cnt += int'(m1Ack);
    if (m1Ack) wdatQ.push_back(datO);
    if (busy && prevBusy == 0) grantQ.push_back(int'(owner));
    prevBusy = int'(busy);
    @(posedge gpuClk);
    mDone = '0;
    modelEdge();
    @(negedge gpuClk);
    if (autoDrop) begin
      for (int m = 0; m < 2; m++) if (mDone[m]) rq[m] = 1'b0;
    end
  endtask

  task automatic clearStats();
    ack0Cnt = 0; ack1Cnt = 0;
    grantQ.delete(); wdatQ.delete();
  endtask

  task automatic doReset();
    rst = 1'b1;
    rq = 2'b11; ackI = 1'b1; dI = 32'hDEAD_BEEF; urg = 1'b1;
    @(negedge gpuClk);
    #1;
    checkAllZero("reset_outputs");
    rq = '0; ackI = 1'b0; urg = 1'b0; dI = '0; wr = '0;
    @(negedge gpuClk);
    rst = 1'b0;
    modelReset();
  endtask

  task automatic newBurst(input int m);
    ad[m] = 20'($urandom);
    cn[m] = 3'($urandom);
    sl[m] = 4'($urandom);
    wr[m] = 1'($urandom);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    modelReset();
    autoDrop = 1'b0;
    clearStats();
    doReset();

    // Both masters requesting 2-beat reads: M0, M1, M0 alternation.
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[3]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[6]  = '{2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[9]  = '{2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    cn[0] = 3'd1; cn[1] = 3'd1;
    for (int i = 0; i < 11; i++) begin
      rq = tbl[i].rq; ackI = tbl[i].ack;
      #1;
      check($sformatf("tbl%0d_busy", i), busy, tbl[i].eBusy);
      if (tbl[i].eBusy) check($sformatf("tbl%0d_owner", i), owner, tbl[i].eOwn);
      check($sformatf("tbl%0d_acks", i), {m0Ack, m1Ack}, {tbl[i].eA0, tbl[i].eA1});
      check($sformatf("tbl%0d_req_o", i), reqO, tbl[i].eReq);
      cyc();
    end

    // M0 alone, 8-beat read.
    clearStats(); autoDrop = 1'b1;
    rq = 2'b01; cn[0] = 3'd7; wr[0] = 1'b0; ackI = 1'b1;
    for (int i = 0; i < 12; i++) begin dI = $urandom; cyc(); end
    check("m0_only_acks0", ack0Cnt, 8);
    check("m0_only_acks1", ack1Cnt, 0);
    check("m0_only_grants", grantQ.size(), 1);

    // Six back-to-back M0 bursts, then M1 joins: M1 must win next.
    clearStats(); autoDrop = 1'b0;
    rq = 2'b01; cn[0] = 3'd0; cn[1] = 3'd0; ackI = 1'b1;
    for (int i = 0; i < 12; i++) cyc();
    rq = 2'b11;
    for (int i = 0; i < 4; i++) cyc();
    autoDrop = 1'b1;
    for (int i = 0; i < 6; i++) cyc();
    check("streak_grants", grantQ.size() >= 7, 1'b1);
    if (grantQ.size() >= 7) begin
      int zeros = 0;
      for (int i = 0; i < 6; i++) if (grantQ[i] == 0) zeros++;
      check("streak_m0_run", zeros, 6);
      check("streak_m1_next", grantQ[6], 1);
    end

    // Urgency raised mid-burst does not preempt.
    clearStats(); autoDrop = 1'b1;
    rq = 2'b01; cn[0] = 3'd7; ackI = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    rq[1] = 1'b1; cn[1] = 3'd2; urg = 1'b1;
    for (int i = 0; i < 14; i++) cyc();
    urg = 1'b0;
    check("urg_acks0", ack0Cnt, 8);
    check("urg_acks1", ack1Cnt, 3);
    check("urg_grants", grantQ.size(), 2);
    if (grantQ.size() == 2) check("urg_order", {grantQ[0][0], grantQ[1][0]}, 2'b01);

    // M1 4-beat write with data 0xA..0xD.
    clearStats(); autoDrop = 1'b1;
    rq = 2'b10; cn[1] = 3'd3; wr[1] = 1'b1; sl[1] = 4'h5; ad[1] = 20'h12340; ackI = 1'b1;
    for (int i = 0; i < 7; i++) begin dw[1] = 32'hA + 32'(ack1Cnt); cyc(); end
    check("wr_beats", wdatQ.size(), 4);
    check("wr_acks0", ack0Cnt, 0);
    for (int i = 0; i < 4 && i < wdatQ.size(); i++)
      check($sformatf("wr_dat%0d", i), wdatQ[i], 32'hA + 32'(i));

    // Asynchronous reset in the middle of a burst.
    clearStats(); autoDrop = 1'b1;
    rq = 2'b01; cn[0] = 3'd7; ackI = 1'b1; dI = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) cyc();
    #2 rst = 1'b1;
    #1 checkAllZero("async_reset");
    modelReset();
    rq = '0; ackI = 1'b0;
    @(negedge gpuClk);
    rst = 1'b0;
    rq = 2'b11; cn[0] = 3'd1; cn[1] = 3'd1; ackI = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    check("post_reset_grants", grantQ.size() >= 1, 1'b1);
    if (grantQ.size() >= 1) check("post_reset_first", grantQ[0], 0);

    // Randomized traffic against the model.
    doReset();
    autoDrop = 1'b0;
    for (int m = 0; m < 2; m++) newBurst(m);
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        if (mDone[m]) begin
          rq[m] = 1'($urandom);
          newBurst(m);
        end else if (!rq[m]) begin
          if ($urandom_range(0, 3) == 0) begin rq[m] = 1'b1; newBurst(m); end
        end else if ($urandom_range(0, 9) == 0) begin
          cn[m] = 3'($urandom);
        end
        dw[m] = $urandom;
      end
      dI   = $urandom;
      ackI = ($urandom_range(0, 2) != 0);
      urg  = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
`default_nettype wire
